// File: rtl/dma_tc_pkg.sv
// Shared types and limits for the DMA timing-and-control block.
package dma_tc_pkg;

  typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, DONE} dma_tc_state_e;

  localparam int DMA_MAX_WAIT = 15;

endpackage

// File: rtl/dma_tc_if.sv
// Control strobes from the timing FSM to the DMA datapath.
interface dma_tc_if;

  logic ProgramMode;
  logic StateRead;
  logic StateWrite;
  logic StateDone;
  logic ior;
  logic iow;

  modport TC (output ProgramMode, StateRead, StateWrite, StateDone, ior, iow);
  modport DP (input  ProgramMode, StateRead, StateWrite, StateDone, ior, iow);

endinterface

// File: rtl/dma_wait_counter.sv
// Phase-length counter: done once WAIT_CYCLES cycles have elapsed since clear.
module dma_wait_counter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic done
);

  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  logic [CW-1:0] count;

  // Saturates at LAST so the count never leaves the legal range.
  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (count != LAST)
      count <= count + 1'b1;
  end

  assign done = (count == LAST);

endmodule

// File: rtl/dma_timing_control.sv
// Timing-and-control FSM for the single-channel block DMA; outputs are
// registered and decoded from the next state.
module dma_timing_control
  import dma_tc_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     cs_n,
  input  logic     dreq,
  input  logic     hlda,
  input  logic     tc,
  output logic     hrq,
  output logic     dack,
  output logic     eop_n,
  dma_tc_if.TC     tc_bus
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > DMA_MAX_WAIT) begin : gWaitRangeCheck
    $error("dma_timing_control: WAIT_CYCLES out of range 0..%0d", DMA_MAX_WAIT);
  end

  dma_tc_state_e state;
  dma_tc_state_e nextState;
  logic          phaseDone;
  logic          counterClear;

  // Counter runs only while a phase persists; any state change restarts it.
  assign counterClear = (nextState != state) || !((state == READ) || (state == WRITE));

  dma_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) uWaitCounter (
    .clk   (clk),
    .reset (reset),
    .clear (counterClear),
    .done  (phaseDone)
  );

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (dreq && cs_n) nextState = REQ;
      REQ:   if (hlda) nextState = READ;
             else if (!dreq) nextState = IDLE;
      READ:  if (!hlda) nextState = IDLE;
             else if (phaseDone) nextState = WRITE;
      WRITE: if (!hlda) nextState = IDLE;
             else if (phaseDone) nextState = tc ? DONE : READ;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  // Output registers load the decode of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      hrq                <= 1'b0;
      dack               <= 1'b0;
      eop_n              <= 1'b1;
      tc_bus.ProgramMode <= 1'b0;
      tc_bus.StateRead   <= 1'b0;
      tc_bus.StateWrite  <= 1'b0;
      tc_bus.StateDone   <= 1'b0;
      tc_bus.ior         <= 1'b0;
      tc_bus.iow         <= 1'b0;
    end else begin
      hrq                <= (nextState != IDLE);
      dack               <= (nextState == READ) || (nextState == WRITE);
      eop_n              <= (nextState != DONE);
      tc_bus.ProgramMode <= (nextState == IDLE) && !cs_n;
      tc_bus.StateRead   <= (nextState == READ);
      tc_bus.StateWrite  <= (nextState == WRITE);
      tc_bus.StateDone   <= (nextState == DONE);
      tc_bus.ior         <= (nextState == READ);
      tc_bus.iow         <= (nextState == WRITE);
    end
  end

endmodule
